// File: rtl/stream_mux_pkg.sv
// Shared constants for the round-robin stream multiplexer.
package stream_mux_pkg;

   localparam int DEF_WIDTH  = 8;
   localparam int DEF_NUM_CH = 4;
   localparam int DEF_SEL_W  = 2;

   typedef enum logic {
      MODE_FIXED = 1'b0,
      MODE_RR    = 1'b1
   } mode_e;

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin arbiter: first requester after ptr (modulo NUM_CH) wins.
module rr_arbiter
   import stream_mux_pkg::*;
#(
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int SEL_W  = DEF_SEL_W
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [SEL_W-1:0]  ptr,
   input  logic              en,
   output logic [SEL_W-1:0]  grant,
   output logic              grant_valid
);

   // Scan farthest-first so the closest requester after ptr is the last write.
   always_comb begin
      grant       = '0;
      grant_valid = 1'b0;
      if (en) begin
         for (int k = NUM_CH; k >= 1; k--) begin
            if (req[(int'(ptr) + k) % NUM_CH]) begin
               grant       = SEL_W'((int'(ptr) + k) % NUM_CH);
               grant_valid = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/stream_mux_rr.sv
// NUM_CH:1 streaming mux with fixed-select or round-robin grant and one registered output stage.
module stream_mux_rr
   import stream_mux_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int SEL_W  = DEF_SEL_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_CH*WIDTH-1:0] in_data,
   input  logic [NUM_CH-1:0]       in_valid,
   output logic [NUM_CH-1:0]       in_ready,
   input  logic [SEL_W-1:0]        sel,
   input  logic                    rr_en,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_ch,
   output logic                    out_valid,
   input  logic                    out_ready
);

   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [SEL_W-1:0] out_ch_q, out_ch_d;
   logic             out_valid_q, out_valid_d;
   logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

   logic             rr_mode;
   logic [SEL_W-1:0] rr_grant;
   logic             rr_gvalid;
   logic             fix_valid;
   logic [SEL_W-1:0] grant;
   logic             grant_valid;
   logic             load_en;
   logic             xfer;
   logic [WIDTH-1:0] grant_data;

   assign rr_mode = (rr_en == MODE_RR);

   rr_arbiter #(
      .NUM_CH (NUM_CH),
      .SEL_W  (SEL_W)
   ) u_arb (
      .req         (in_valid),
      .ptr         (rr_ptr_q),
      .en          (rr_mode),
      .grant       (rr_grant),
      .grant_valid (rr_gvalid)
   );

   // Out-of-range sel matches no channel, so it never grants.
   always_comb begin
      fix_valid = 1'b0;
      for (int i = 0; i < NUM_CH; i++)
         if (sel == SEL_W'(i) && in_valid[i]) fix_valid = 1'b1;
   end

   assign grant       = rr_mode ? rr_grant  : sel;
   assign grant_valid = rr_mode ? rr_gvalid : fix_valid;
   assign load_en     = !out_valid_q || out_ready;
   assign xfer        = load_en && grant_valid;

   always_comb begin
      in_ready   = '0;
      grant_data = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (grant == SEL_W'(i)) begin
            in_ready[i] = xfer;
            grant_data  = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      out_valid_d = out_valid_q;
      rr_ptr_d    = rr_ptr_q;
      if (xfer) begin
         out_data_d  = grant_data;
         out_ch_d    = grant;
         out_valid_d = 1'b1;
         rr_ptr_d    = grant;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_q  <= '0;
         out_ch_q    <= '0;
         out_valid_q <= 1'b0;
         rr_ptr_q    <= SEL_W'(NUM_CH - 1);
      end else begin
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         out_valid_q <= out_valid_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: a 4-channel instance plus a 3-channel one for out-of-range sel.
module tb_stream_mux_rr;

   logic        clk = 1'b0;
   logic        rst_n;

   logic [31:0] a_in_data;
   logic [3:0]  a_in_valid, a_in_ready;
   logic [1:0]  a_sel, a_out_ch;
   logic        a_rr_en, a_out_valid, a_out_ready;
   logic [7:0]  a_out_data;

   logic [23:0] b_in_data;
   logic [2:0]  b_in_valid, b_in_ready;
   logic [1:0]  b_sel, b_out_ch;
   logic        b_rr_en, b_out_valid, b_out_ready;
   logic [7:0]  b_out_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   stream_mux_rr #(.WIDTH(8), .NUM_CH(4), .SEL_W(2)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .sel(a_sel), .rr_en(a_rr_en),
      .out_data(a_out_data), .out_ch(a_out_ch), .out_valid(a_out_valid),
      .out_ready(a_out_ready)
   );

   stream_mux_rr #(.WIDTH(8), .NUM_CH(3), .SEL_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .sel(b_sel), .rr_en(b_rr_en),
      .out_data(b_out_data), .out_ch(b_out_ch), .out_valid(b_out_valid),
      .out_ready(b_out_ready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_a(input string tag, input logic [7:0] d, input logic [1:0] ch, input logic v);
      chk({tag, ".data"},  32'(a_out_data),  32'(d));
      chk({tag, ".ch"},    32'(a_out_ch),    32'(ch));
      chk({tag, ".valid"}, 32'(a_out_valid), 32'(v));
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      rst_n       = 1'b0;
      a_in_data   = '0; a_in_valid = '0; a_sel = '0; a_rr_en = 1'b0; a_out_ready = 1'b0;
      b_in_data   = {8'h03, 8'h02, 8'h01}; b_in_valid = '0; b_sel = '0; b_rr_en = 1'b0;
      b_out_ready = 1'b1;

      // Reset and idle
      tick(); tick();
      chk_a("rst", 8'h00, 2'd0, 1'b0);
      chk("rst.in_ready", 32'(a_in_ready), 32'h0);
      rst_n = 1'b1;
      tick(); tick();
      chk_a("idle", 8'h00, 2'd0, 1'b0);
      chk("idle.in_ready", 32'(a_in_ready), 32'h0);

      // Fixed select, ch0 also valid but must be ignored
      a_rr_en = 1'b0; a_sel = 2'd2; a_out_ready = 1'b1;
      a_in_data  = {8'h00, 8'hA5, 8'h00, 8'h11};
      a_in_valid = 4'b0101;
      #1 chk("fix.in_ready", 32'(a_in_ready), 32'b0100);
      tick();
      chk_a("fix.out", 8'hA5, 2'd2, 1'b1);
      chk("fix.in_ready2", 32'(a_in_ready), 32'b0100);
      tick();
      chk_a("fix.out2", 8'hA5, 2'd2, 1'b1);
      a_in_valid = 4'b0000;
      tick();
      chk_a("fix.drain", 8'hA5, 2'd2, 1'b0);

      // Re-reset so the pointer starts at NUM_CH-1 for the fairness run
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;

      // Round-robin fairness
      a_rr_en = 1'b1;
      a_in_data  = {8'h40, 8'h30, 8'h20, 8'h10};
      a_in_valid = 4'b1111;
      #1 chk("rr.in_ready", 32'(a_in_ready), 32'b0001);
      tick(); chk_a("rr.0", 8'h10, 2'd0, 1'b1);
      tick(); chk_a("rr.1", 8'h20, 2'd1, 1'b1);
      tick(); chk_a("rr.2", 8'h30, 2'd2, 1'b1);
      tick(); chk_a("rr.3", 8'h40, 2'd3, 1'b1);
      tick(); chk_a("rr.4", 8'h10, 2'd0, 1'b1);
      tick(); chk_a("rr.5", 8'h20, 2'd1, 1'b1);

      // Backpressure holding 0x20 from ch1
      a_out_ready = 1'b0;
      #1 chk("bp.in_ready", 32'(a_in_ready), 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_a("bp.hold", 8'h20, 2'd1, 1'b1);
         chk("bp.in_ready_hold", 32'(a_in_ready), 32'h0);
      end
      a_out_ready = 1'b1;
      #1 chk("bp.release_ready", 32'(a_in_ready), 32'b0100);
      tick(); chk_a("bp.reload", 8'h30, 2'd2, 1'b1);

      // Wrap-around: move pointer to 1, then only ch0 requests
      a_in_valid = 4'b0010;
      tick(); chk_a("wrap.ptr1", 8'h20, 2'd1, 1'b1);
      a_in_valid = 4'b0001;
      #1 chk("wrap.in_ready", 32'(a_in_ready), 32'b0001);
      tick(); chk_a("wrap.ch0", 8'h10, 2'd0, 1'b1);

      // 3-channel instance: sel=3 is out of range
      b_in_valid = 3'b111; b_sel = 2'd1;
      tick();
      chk("oor.pre_valid", 32'(b_out_valid), 32'h1);
      chk("oor.pre_data", 32'(b_out_data), 32'h02);
      b_sel = 2'd3;
      #1 chk("oor.in_ready", 32'(b_in_ready), 32'h0);
      tick();
      chk("oor.valid", 32'(b_out_valid), 32'h0);
      chk("oor.data_hold", 32'(b_out_data), 32'h02);
      chk("oor.ch_hold", 32'(b_out_ch), 32'h1);

      // Reset mid-stream: output clears before the next clock edge
      a_in_valid  = 4'b0010;
      a_out_ready = 1'b0;
      tick();
      chk("mid.pre_valid", 32'(a_out_valid), 32'h1);
      #2 rst_n = 1'b0;
      #1 chk_a("mid.async", 8'h00, 2'd0, 1'b0);
      tick();
      a_in_valid  = 4'b0011;
      a_out_ready = 1'b1;
      rst_n = 1'b1;
      #1 chk("mid.first_ready", 32'(a_in_ready), 32'b0001);
      tick(); chk_a("mid.first", 8'h10, 2'd0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised successor to the team's 2:1 combinational mux: NUM_CH-input, WIDTH-bit streaming multiplexer with one registered output stage.
- Per-channel valid/ready handshake on every input and on the output.
- Two selection modes: fixed select (external sel) and round-robin arbitration.
- Sits between multiple producers and one shared consumer (e.g. a shared bus or output port).

Parameters:
- WIDTH, 8, data width per channel
- NUM_CH, 4, number of input channels (>= 2)
- SEL_W, 2, width of sel/out_ch; must satisfy 2**SEL_W >= NUM_CH

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  NUM_CH*WIDTH  flattened channel data; channel i = bits [i*WIDTH +: WIDTH]
- in_valid  input  NUM_CH  per-channel valid
- in_ready  output  NUM_CH  per-channel ready (combinational)
- sel  input  SEL_W  channel select, used when rr_en=0
- rr_en  input  1  1 = round-robin mode, 0 = fixed select
- out_data  output  WIDTH  registered output data
- out_ch  output  SEL_W  index of the channel that supplied out_data
- out_valid  output  1  output valid
- out_ready  input  1  consumer ready

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_ch=0, rr_ptr=NUM_CH-1, so channel 0 has first priority.
- load_en = !out_valid || out_ready; the output register accepts new data only when it is empty or being drained this cycle.
- Grant, fixed mode (rr_en=0):
  - grant = sel when sel < NUM_CH and in_valid[sel]=1; otherwise no grant.
  - sel >= NUM_CH never grants.
- Grant, round-robin mode (rr_en=1):
  - Search channels rr_ptr+1, rr_ptr+2, ... modulo NUM_CH.
  - The first channel with in_valid=1 wins.
  - No valid channel means no grant.
- in_ready[i] = load_en && grant_valid && (grant == i); at most one bit is high per cycle. in_ready must not depend on in_valid of channel i alone.
- Transfer:
  - On a clk edge where in_valid[g] && in_ready[g]: out_data <= channel g data, out_ch <= g, out_valid <= 1.
  - Else, if out_ready=1: out_valid <= 0, and out_data/out_ch hold their last values.
- Latency and throughput: input-to-output latency is 1 cycle. Sustained throughput is 1 word/cycle while out_ready=1.
- Backpressure: with out_valid=1 and out_ready=0, out_data, out_ch and out_valid hold and all in_ready are 0.
- rr_ptr update:
  - Updates to g only on an accepted input transfer; this happens in both modes.
  - With no transfer, rr_ptr holds.
- Mode or sel changes take effect in the same cycle, combinationally. The pointer is retained across mode switches.
- Simultaneous drain and load (out_valid=1, out_ready=1, new grant): the new word replaces the old one in the same edge, with no bubble.
- Reset mid-transfer: the output is cleared immediately and any in-flight word is dropped. The bench must not expect delivery of that word.
- Wrap-around: the search from rr_ptr=NUM_CH-1 starts at channel 0.
- Producers are expected to hold in_data stable while in_valid=1 and ready=0. The block does not check this.

Decomposition:
- Shared header/package (stream_mux_pkg): default WIDTH/NUM_CH constants, and a MODE_FIXED=0 / MODE_RR=1 encoding for rr_en.
- Sub-module rr_arbiter:
  - Inputs: req[NUM_CH], ptr, en.
  - Outputs: grant index, grant_valid.
  - Purely combinational.
- The top level holds rr_ptr, the output register and the in_ready decode.

Test Plan (WIDTH=8, NUM_CH=4):
- Reset, then idle: rst_n=0 for 2 cycles, all in_valid=0 -> out_valid=0, out_data=0x00, out_ch=0, in_ready=0000, all held after release.
- Fixed mode: rr_en=0, sel=2, ch2=0xA5 valid, ch0=0x11 valid, out_ready=1 -> in_ready=0100; next cycle out_data=0xA5, out_ch=2, out_valid=1; ch0 is never granted.
- Round-robin fairness: rr_en=1, all 4 channels valid with data 0x10/0x20/0x30/0x40 held, out_ready=1 -> output sequence ch 0,1,2,3,0,... with data 0x10,0x20,0x30,0x40,0x10 on consecutive cycles.
- Backpressure: out_valid=1 with out_data=0x20, out_ready=0 for 3 cycles -> out_data stays 0x20 and in_ready=0000 throughout; out_ready=1 -> next word loads on the same edge as the drain.
- Out-of-range and sparse requests:
  - rr_en=0, sel=3 with NUM_CH=3 instance -> no grant, out_valid falls to 0.
  - rr_en=1, rr_ptr=1, only ch0 valid -> ch0 is granted via wrap-around.
- Reset mid-stream: assert rst_n=0 while out_valid=1 and ch1 valid -> out_valid goes 0 asynchronously, before the next clk edge; after release the first grant goes to ch0 if valid.
